fsm_stim_driver: RTL and testbench

- Self-checking stimulus source for the lab's two-input, two-output clocked state machines (inputs a,b; outputs y,z; state held in falling-edge D flip-flops).
- Replays a programmed vector sequence onto a,b, samples y,z once per clock, compares each sample against programmed expected values, and reports pass/fail.
- Sits on the opposite side of the a/b -> y/z interface from the FSM under test.
- Launches on the rising edge so the DUT always sees stable inputs at its falling edge.

---
 rtl/fsm_stim_driver.sv | 180 ++++++++++++++++++
 tb/tb_fsm_stim_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_stim_driver.sv
// fsm_stim_driver
// Self-checking stimulus source for a two-input/two-output clocked FSM whose
// state flops are falling-edge. A programmed vector table is replayed on a,b
// (launched on the rising edge). The y,z response is sampled on the next
// rising edge and compared with the programmed expectation.
//
// Optional build macro: STIM_STOP_ON_FAIL_EN. When it is defined, the run
// stops at the first mismatch.
//
// Ports:
//   clk, rst_n                 rising-edge clock, async active-low reset
//   load_en/load_addr/load_ab/load_exp  vector table write (IDLE/DONE only)
//   len, start                 run slots 0..len (start honoured in IDLE/DONE)
//   y, z                       response from the FSM under test
//   a, b                       stimulus to the FSM under test
//   busy, done, pass           run status
//   err_count, fail_valid, fail_idx  mismatch statistics for the last run
module fsm_stim_driver #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [1:0]    load_ab,
    input  logic [1:0]    load_exp,
    input  logic [AW-1:0] len,
    input  logic          start,
    input  logic          y,
    input  logic          z,
    output logic          a,
    output logic          b,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic          fail_valid,
    output logic [AW-1:0] fail_idx
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [AW-1:0] IDX_ONE = 1;
    localparam logic [AW:0]   ERR_ONE = 1;

    // Vector table; intentionally not reset so a run can be replayed after reset.
    logic [1:0] ab_mem  [DEPTH];
    logic [1:0] exp_mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] len_q, len_d;
    logic          a_q, a_d, b_q, b_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [AW:0]   err_q, err_d;
    logic          fv_q, fv_d;
    logic [AW-1:0] fi_q, fi_d;

    logic idle_like;
    logic wr_en;
    logic mismatch;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign wr_en     = load_en && idle_like;
    assign mismatch  = ({y, z} != exp_mem[idx_q]);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ab_mem[load_addr]  <= load_ab;
            exp_mem[load_addr] <= load_exp;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fi_d    = fi_q;

        case (state_q)
            IDLE, DONE: begin
                // A write in the same cycle takes priority over start.
                if (start && !load_en) begin
                    len_d      = len;
                    err_d      = '0;
                    fv_d       = 1'b0;
                    fi_d       = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    {a_d, b_d} = ab_mem[0];
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // y,z here are the response to the vector still on a,b (idx_q).
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        fi_d = idx_q;
                    end
                end
`ifdef STIM_STOP_ON_FAIL_EN
                if (mismatch || (idx_q == len_q)) begin
                    state_d = FLUSH;
                end else begin
                    idx_d      = idx_q + IDX_ONE;
                    {a_d, b_d} = ab_mem[idx_q + IDX_ONE];
                end
`else
                if (idx_q == len_q) begin
                    state_d = FLUSH;
                end else begin
                    idx_d      = idx_q + IDX_ONE;
                    {a_d, b_d} = ab_mem[idx_q + IDX_ONE];
                end
`endif
            end
            FLUSH: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fi_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fi_q    <= fi_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_idx   = fi_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Bench for fsm_stim_driver. The responder is either a combinational loopback
// (y=a, z=b) or a small two-input FSM with falling-edge state flops.
module tb_fsm_stim_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_addr = '0;
    logic [1:0] load_ab = '0;
    logic [1:0] load_exp = '0;
    logic [3:0] len = '0;
    logic       start = 1'b0;
    logic       y, z, a, b, busy, done, pass, fail_valid;
    logic [4:0] err_count;
    logic [3:0] fail_idx;

    logic       lb = 1'b1;        // 1: loopback responder, 0: falling-edge FSM
    logic [1:0] fsm_s;

    int checks = 0;
    int failures = 0;
    int mem_ab [16];
    int mem_exp[16];

    always #5 clk = ~clk;

    // Lab-style FSM: s' = {s[0]^a, b}; Moore outputs y=s[1], z=s[0].
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) fsm_s <= 2'b00;
        else        fsm_s <= {fsm_s[0] ^ a, b};
    end

    assign y = lb ? a : fsm_s[1];
    assign z = lb ? b : fsm_s[0];

    fsm_stim_driver #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_ab(load_ab), .load_exp(load_exp), .len(len), .start(start),
        .y(y), .z(z), .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input int ab, input int ex);
        load_en   = 1'b1;
        load_addr = 4'(addr);
        load_ab   = 2'(ab);
        load_exp  = 2'(ex);
        tick();
        load_en = 1'b0;
        mem_ab[addr]  = ab;
        mem_exp[addr] = ex;
    endtask

    // Run slots 0..ln and compare status/timing against a list-based model.
    task automatic run(input string nm, input int ln, input bit disturb);
        int s = 0;
        int r, nerr = 0, first = -1, nrun, ecnt, lat, e, vi;
        for (int i = 0; i <= ln; i++) begin
            if (lb) r = mem_ab[i];
            else begin
                s = (((s & 1) ^ ((mem_ab[i] >> 1) & 1)) << 1) | (mem_ab[i] & 1);
                r = s;
            end
            if (r != mem_exp[i]) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
`ifdef STIM_STOP_ON_FAIL_EN
        nrun = (first >= 0) ? first + 1 : ln + 1;
        ecnt = (first >= 0) ? 1 : 0;
`else
        nrun = ln + 1;
        ecnt = nerr;
`endif
        lat = nrun + 2;

        len   = 4'(ln);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (e = 1; e < lat + 4; e++) begin
            if (e > 1) tick();
            if (disturb) begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            if (done) break;
            vi = (e <= nrun) ? e - 1 : nrun - 1;
            chk({nm, " ab"}, int'({a, b}), mem_ab[vi]);
            chk({nm, " busy"}, int'(busy), 1);
            if (disturb && e < lat - 1) begin
                load_en   = 1'b1;
                start     = 1'b1;
                load_addr = 4'($urandom_range(0, 15));
                load_ab   = 2'($urandom);
                load_exp  = 2'($urandom);
            end
        end
        chk({nm, " latency"}, e, lat);
        chk({nm, " pass"}, int'(pass), (ecnt == 0) ? 1 : 0);
        chk({nm, " err_count"}, int'(err_count), ecnt);
        chk({nm, " fail_valid"}, int'(fail_valid), (first >= 0) ? 1 : 0);
        chk({nm, " fail_idx"}, int'(fail_idx), (first >= 0) ? first : 0);
        chk({nm, " ab_idle"}, int'({a, b}), 0);
        chk({nm, " busy_end"}, int'(busy), 0);
        // Let the responder FSM settle back to 00 with a,b=0.
        repeat (3) tick();
    endtask

    initial begin
        int sel, flip;
        #12;
        chk("rst a", int'(a), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err_count), 0);
        chk("rst fv", int'(fail_valid), 0);
        chk("rst fi", int'(fail_idx), 0);
        rst_n = 1'b1;
        tick();

        // Directed loopback pattern, clean then corrupted.
        load(0, 1, 1); load(1, 2, 2); load(2, 3, 3); load(3, 0, 0);
        run("lb4", 3, 1'b0);
        load(1, 2, 3); load(3, 0, 1);
        run("lb4bad", 3, 1'b0);

        // Single vector.
        load(0, 2, 2);
        run("len0", 0, 1'b0);

        // Full table, no index wrap.
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 3));
            load(i, sel, sel);
        end
        run("len15", 15, 1'b0);

        // Reset two cycles into a run, then replay retained memory.
        len   = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst ab", int'({a, b}), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst err", int'(err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        run("replay", 15, 1'b0);

        // Load/start pulses during the run must be ignored.
        run("disturb", 15, 1'b1);

        // start with load_en in IDLE/DONE: write only.
        load_en = 1'b1; start = 1'b1;
        load_addr = 4'd0; load_ab = 2'd3; load_exp = 2'd0;
        tick();
        load_en = 1'b0; start = 1'b0;
        mem_ab[0] = 3; mem_exp[0] = 0;
        tick();
        chk("ldstart busy", int'(busy), 0);
        run("ldstart", 2, 1'b0);

        // Falling-edge FSM responder, exp taken from the model's own table.
        lb = 1'b0;
        begin
            int s = 0;
            for (int i = 0; i < 8; i++) begin
                sel = int'($urandom_range(0, 3));
                s = (((s & 1) ^ ((sel >> 1) & 1)) << 1) | (sel & 1);
                load(i, sel, s);
            end
        end
        run("fsm8", 7, 1'b0);
        load(5, mem_ab[5], mem_exp[5] ^ 1);
        run("fsm8bad", 7, 1'b0);

        // Randomized runs on both responders.
        for (int t = 0; t < 16; t++) begin
            lb = 1'($urandom);
            for (int i = 0; i < 16; i++) begin
                sel  = int'($urandom_range(0, 3));
                flip = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
                load(i, sel, sel ^ flip);
            end
            // For the FSM responder, rebuild expectations from the model then perturb.
            if (!lb) begin
                int s = 0;
                for (int i = 0; i < 16; i++) begin
                    s = (((s & 1) ^ ((mem_ab[i] >> 1) & 1)) << 1) | (mem_ab[i] & 1);
                    flip = ($urandom_range(0, 7) == 0) ? 1 : 0;
                    load(i, mem_ab[i], s ^ flip);
                end
            end
            run("rand", int'($urandom_range(0, 15)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
